load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequencer between the CPU memory stage and the 1024x32 word RAM. It turns byte-addressed load/store requests of byte, halfword or word size into RAM word accesses. Sub-word stores use read-modify-write because the RAM has no byte enables. Loads are extracted and sign/zero-extended. Misaligned or illegal requests are rejected without touching the RAM.

## Interface
No parameters; the RAM geometry is fixed at 1024 words x 32 bits.
- clk  in  1  rising-edge clock, shared with the RAM
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  request; sampled only when ready=1
- we  in  1  1 = store, 0 = load
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  12  byte address; word index is addr[11:2]
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- ready  out  1  1 when in IDLE; a request is accepted on a clk edge with ready=1 and req=1
- done  out  1  registered one-cycle completion pulse
- misalign  out  1  registered; valid with done; 1 = request rejected
- rdata  out  32  registered load result; valid with done for loads
- ram_addr  out  10  RAM word address
- ram_din  out  32  RAM write data
- ram_str  out  1  RAM store strobe
- ram_ld  out  1  RAM load strobe
- ram_dout  in  32  RAM read data; valid the cycle after ram_ld

## Operation
- On acceptance, latch we, size, sign_ext, addr and wdata.
- States: IDLE, RD, EXT, WR.
- Alignment error: size=11, or half with addr[0]=1, or word with addr[1:0]!=0.
  - Stay in IDLE and set done=1, misalign=1.
  - Leave rdata unchanged and do not strobe the RAM.
- Load: IDLE -> RD -> EXT -> IDLE.
- Word store: IDLE -> WR -> IDLE.
- Byte or half store: IDLE -> RD -> WR -> IDLE.
- RAM strobes:
  - RD: ram_ld=1.
  - WR: ram_str=1.
  - IDLE and EXT: both 0.
  - ram_ld and ram_str are never high together.
  - ram_addr is the latched addr[11:2] in every non-IDLE state and 0 in IDLE.
- Byte lanes are big-endian: byte offset k occupies ram word bits [31-8k : 24-8k]; halfword offset 0 is [31:16] and offset 2 is [15:0].
- EXT (load extract):
  - The selected lane of ram_dout is extended to 32 bits according to the latched sign_ext.
  - A word load passes through unchanged.
- WR (store data):
  - Word store: ram_din = latched wdata.
  - Sub-word store: ram_din = ram_dout with the selected lane replaced by wdata[7:0] or wdata[15:0]. All other bits are preserved exactly.
- On the edge that leaves EXT or WR, set done=1 and misalign=0. Leaving EXT also loads rdata.
- Each done pulse lasts exactly one cycle.
- req is ignored while ready=0. The requester holds req and its operands until acceptance.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE; done=0, misalign=0, rdata=0; latched fields=0.
  - Consequently ram_ld=0, ram_str=0, ram_addr=0, ram_din=0, and ready=1.
- Reset mid-operation:
  - Reset before the WR edge: the RAM is not written.
  - A pending done is cancelled.
- Cycle counts from the accepting edge E0 to the first cycle with done=1:
  - Misaligned: done after E0 (1 cycle).
  - Word store: RAM written at E1; done after E1.
  - Load: RAM read at E1, rdata captured at E2; done after E2.
  - Sub-word store: read at E1, write at E2; done after E2.
- ready returns to 1 in the same cycle done is high. A request in that cycle is accepted, giving back-to-back throughput.
- A sub-word store immediately followed by a load of the same word returns the merged data, because the write completes before the read.

## Test plan
- Word store/load round trip:
  - Reset, then store word 0xDEADBEEF at addr 0x010 -> ram_str pulses once with ram_addr=4; done 2 cycles after request.
  - Load word at 0x010 -> rdata=0xDEADBEEF, misalign=0, done 3 cycles after request.
- Byte RMW:
  - With word 4 = 0x11223344, store byte 0xAB at addr 0x012 -> one ram_ld, then one ram_str with ram_din=0x1122AB44.
- Sign handling:
  - With word 4 = 0x1122AB44, load byte addr 0x012 with sign_ext=1 -> rdata=0xFFFFFFAB.
  - Same load with sign_ext=0 -> rdata=0x000000AB.
  - Load half addr 0x010 with sign_ext=1 -> rdata=0x00001122.
- Misalignment:
  - Half load at 0x011, word store at 0x012, and size=11 -> each gives done+misalign one cycle later, with no ram_ld/ram_str and rdata unchanged.
- Back-to-back and reset:
  - Hold req high over 4 alternating store/load requests -> each accepted in the cycle done is high, with correct data throughout.
  - Assert rst_n=0 during RD of a byte store -> no ram_str, state IDLE, done=0.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
// Sequences byte/halfword/word loads and stores from the CPU memory stage onto
// a 1024x32 word RAM that has no byte enables. Sub-word stores are performed as
// read-modify-write, loads are lane-selected and sign/zero-extended, and
// misaligned or illegal requests are rejected without any RAM access.

module load_store_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [11:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        done,
   output logic        misalign,
   output logic [31:0] rdata,
   output logic [9:0]  ram_addr,
   output logic [31:0] ram_din,
   output logic        ram_str,
   output logic        ram_ld,
   input  logic [31:0] ram_dout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      EXT  = 2'd2,
      WR   = 2'd3
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   state_t      state;
   logic        lat_we;
   logic [1:0]  lat_size;
   logic        lat_sext;
   logic [11:0] lat_addr;
   logic [31:0] lat_wdata;

   logic        req_bad;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_value;
   logic [31:0] merged;
   logic [31:0] store_word;

   // Flag requests whose size is illegal or whose address is not naturally aligned
   always_comb begin
      req_bad = 1'b0;
      if (size == 2'b11)
         req_bad = 1'b1;
      else if (size == SIZE_HALF && addr[0])
         req_bad = 1'b1;
      else if (size == SIZE_WORD && addr[1:0] != 2'b00)
         req_bad = 1'b1;
   end

   // Pick the big-endian lane out of the RAM word and extend it for a load
   always_comb begin
      ld_byte  = 8'h00;
      ld_half  = 16'h0000;
      ld_value = ram_dout;
      case (lat_addr[1:0])
         2'd0:    ld_byte = ram_dout[31:24];
         2'd1:    ld_byte = ram_dout[23:16];
         2'd2:    ld_byte = ram_dout[15:8];
         default: ld_byte = ram_dout[7:0];
      endcase
      ld_half = lat_addr[1] ? ram_dout[15:0] : ram_dout[31:16];
      case (lat_size)
         SIZE_BYTE: ld_value = {{24{lat_sext & ld_byte[7]}}, ld_byte};
         SIZE_HALF: ld_value = {{16{lat_sext & ld_half[15]}}, ld_half};
         default:   ld_value = ram_dout;
      endcase
   end

   // Build the word to write: whole word for word stores, otherwise the old word with one lane replaced
   always_comb begin
      merged = ram_dout;
      if (lat_size == SIZE_BYTE) begin
         case (lat_addr[1:0])
            2'd0:    merged[31:24] = lat_wdata[7:0];
            2'd1:    merged[23:16] = lat_wdata[7:0];
            2'd2:    merged[15:8]  = lat_wdata[7:0];
            default: merged[7:0]   = lat_wdata[7:0];
         endcase
      end else if (lat_size == SIZE_HALF) begin
         if (lat_addr[1])
            merged[15:0] = lat_wdata[15:0];
         else
            merged[31:16] = lat_wdata[15:0];
      end
      store_word = (lat_size == SIZE_WORD) ? lat_wdata : merged;
   end

   // RAM side signals decode straight from the state register so they are glitch-free and never overlap
   assign ready    = (state == IDLE);
   assign ram_ld   = (state == RD);
   assign ram_str  = (state == WR);
   assign ram_addr = (state == IDLE) ? 10'd0 : lat_addr[11:2];
   assign ram_din  = (state == WR) ? store_word : 32'd0;

   // Main sequencer: accepts requests in IDLE, walks the RD/EXT/WR steps and raises the one-cycle done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lat_we    <= 1'b0;
         lat_size  <= 2'b00;
         lat_sext  <= 1'b0;
         lat_addr  <= 12'd0;
         lat_wdata <= 32'd0;
         done      <= 1'b0;
         misalign  <= 1'b0;
         rdata     <= 32'd0;
      end else begin
         done     <= 1'b0;
         misalign <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  lat_we    <= we;
                  lat_size  <= size;
                  lat_sext  <= sign_ext;
                  lat_addr  <= addr;
                  lat_wdata <= wdata;
                  if (req_bad) begin
                     done     <= 1'b1;
                     misalign <= 1'b1;
                  end else if (we && size == SIZE_WORD) begin
                     state <= WR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            RD: begin
               state <= lat_we ? WR : EXT;
            end
            EXT: begin
               rdata <= ld_value;
               done  <= 1'b1;
               state <= IDLE;
            end
            WR: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Directed-vector bench for load_store_unit with a behavioural 1024x32 RAM.
// Stimulus pushes hand-computed expectations into a scoreboard queue; a monitor
// pops and compares whenever the DUT pulses done.

module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        sign_ext = 1'b0;
   logic [11:0] addr = 12'd0;
   logic [31:0] wdata = 32'd0;
   logic        ready;
   logic        done;
   logic        misalign;
   logic [31:0] rdata;
   logic [9:0]  ram_addr;
   logic [31:0] ram_din;
   logic        ram_str;
   logic        ram_ld;
   logic [31:0] ram_dout = 32'd0;

   logic [31:0] mem [1024] = '{default: 32'h0};

   typedef struct {
      bit          mis;
      logic [31:0] rd;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ld_count = 0;
   int          str_count = 0;
   logic [9:0]  last_str_addr = 10'd0;
   logic [31:0] last_str_din = 32'd0;
   logic [31:0] model_rdata = 32'd0;

   load_store_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .we       (we),
      .size     (size),
      .sign_ext (sign_ext),
      .addr     (addr),
      .wdata    (wdata),
      .ready    (ready),
      .done     (done),
      .misalign (misalign),
      .rdata    (rdata),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_str  (ram_str),
      .ram_ld   (ram_ld),
      .ram_dout (ram_dout)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Edge counter used to measure completion latency
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural synchronous RAM: write on strobe, read data valid the cycle after ram_ld
   always @(posedge clk) begin
      if (ram_str) mem[ram_addr] <= ram_din;
      if (ram_ld)  ram_dout <= mem[ram_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Monitor: strobe bookkeeping and scoreboard comparison on every done pulse
   always @(negedge clk) begin
      if (rst_n) begin
         if (ram_ld || ram_str)
            checkOutput("strobe_exclusive", 32'(ram_ld & ram_str), 32'd0);
         if (ram_ld) ld_count++;
         if (ram_str) begin
            str_count++;
            last_str_addr = ram_addr;
            last_str_din  = ram_din;
         end
         if (done) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_done", 32'(done), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               checkOutput("misalign", 32'(misalign), 32'(e.mis));
               checkOutput("rdata", rdata, e.rd);
               checkOutput("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
         end
      end
   end

   // Issue one request, wait (bounded) for acceptance and push its expected outcome
   task automatic applyStimulus(input bit w, input logic [1:0] sz, input bit sx, input logic [11:0] a,
                                input logic [31:0] d, input logic [31:0] exp_rd, input int exp_lat,
                                input bit exp_mis, input bit hold);
      int guard;
      exp_t e;
      @(negedge clk);
      we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
      guard = 0;
      while (!ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!ready) begin
         checkOutput("accept_timeout", 32'(ready), 32'd1);
         req = 1'b0;
         return;
      end
      if (!w && !exp_mis) model_rdata = exp_rd;
      e.mis = exp_mis;
      e.rd  = model_rdata;
      e.lat = exp_lat;
      e.acc = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      if (!hold) begin
         #1 req = 1'b0;
      end
   endtask

   // Wait (bounded) until every issued request has completed
   task automatic waitIdle();
      int guard;
      guard = 0;
      while ((sb.size() != 0 || !ready) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int ld0, st0;
      $display("[TB] start");
      repeat (3) @(negedge clk);
      checkOutput("reset_ready", 32'(ready), 32'd1);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_rdata", rdata, 32'd0);
      checkOutput("reset_ram_addr", 32'(ram_addr), 32'd0);
      checkOutput("reset_ram_din", ram_din, 32'd0);
      checkOutput("reset_strobes", 32'({ram_ld, ram_str}), 32'd0);
      rst_n = 1'b1;

      // Word store then word load round trip
      st0 = str_count;
      applyStimulus(1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 32'h0, 1, 0, 0);
      waitIdle();
      checkOutput("wstore_str_count", 32'(str_count - st0), 32'd1);
      checkOutput("wstore_addr", 32'(last_str_addr), 32'd4);
      checkOutput("wstore_din", last_str_din, 32'hDEADBEEF);
      applyStimulus(0, 2'b10, 0, 12'h010, 32'h0, 32'hDEADBEEF, 2, 0, 0);
      waitIdle();

      // Byte read-modify-write
      applyStimulus(1, 2'b10, 0, 12'h010, 32'h11223344, 32'h0, 1, 0, 0);
      waitIdle();
      ld0 = ld_count; st0 = str_count;
      applyStimulus(1, 2'b00, 0, 12'h012, 32'h000000AB, 32'h0, 2, 0, 0);
      waitIdle();
      checkOutput("rmw_ld_count", 32'(ld_count - ld0), 32'd1);
      checkOutput("rmw_str_count", 32'(str_count - st0), 32'd1);
      checkOutput("rmw_din", last_str_din, 32'h1122AB44);

      // Sign and zero extension
      applyStimulus(0, 2'b00, 1, 12'h012, 32'h0, 32'hFFFFFFAB, 2, 0, 0);
      applyStimulus(0, 2'b00, 0, 12'h012, 32'h0, 32'h000000AB, 2, 0, 0);
      applyStimulus(0, 2'b01, 1, 12'h012, 32'h0, 32'hFFFFAB44, 2, 0, 0);
      applyStimulus(0, 2'b01, 1, 12'h010, 32'h0, 32'h00001122, 2, 0, 0);
      waitIdle();

      // Misaligned and illegal requests: rdata holds 0x00001122, no RAM strobes
      ld0 = ld_count; st0 = str_count;
      applyStimulus(0, 2'b01, 1, 12'h011, 32'h0, 32'h0, 0, 1, 0);
      applyStimulus(1, 2'b10, 0, 12'h012, 32'h12345678, 32'h0, 0, 1, 0);
      applyStimulus(0, 2'b11, 0, 12'h000, 32'h0, 32'h0, 0, 1, 0);
      waitIdle();
      checkOutput("mis_ld_count", 32'(ld_count - ld0), 32'd0);
      checkOutput("mis_str_count", 32'(str_count - st0), 32'd0);
      checkOutput("mis_mem_word4", mem[4], 32'h1122AB44);

      // Back-to-back with req held high: word store, word load, byte store, half load
      applyStimulus(1, 2'b10, 0, 12'h040, 32'hCAFEF00D, 32'h0, 1, 0, 1);
      applyStimulus(0, 2'b10, 0, 12'h040, 32'h0, 32'hCAFEF00D, 2, 0, 1);
      applyStimulus(1, 2'b00, 0, 12'h043, 32'h0000005A, 32'h0, 2, 0, 1);
      applyStimulus(0, 2'b01, 0, 12'h042, 32'h0, 32'h0000F05A, 2, 0, 0);
      waitIdle();
      checkOutput("b2b_mem_word16", mem[16], 32'hCAFEF05A);

      // Reset during the RD step of a byte store
      st0 = str_count;
      applyStimulus(1, 2'b00, 0, 12'h020, 32'h00000099, 32'h0, 2, 0, 0);
      @(negedge clk);
      checkOutput("rst_in_rd", 32'(ram_ld), 32'd1);
      rst_n = 1'b0;
      sb.delete();
      model_rdata = 32'd0;
      @(negedge clk);
      checkOutput("rst_ready", 32'(ready), 32'd1);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_rdata", rdata, 32'd0);
      checkOutput("rst_no_str", 32'(ram_str), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("rst_str_count", 32'(str_count - st0), 32'd0);
      checkOutput("rst_mem_word8", mem[8], 32'h0);
      checkOutput("rst_done_after", 32'(done), 32'd0);

      // Unit still works after the interrupted operation
      applyStimulus(0, 2'b01, 1, 12'h040, 32'h0, 32'hFFFFCAFE, 2, 0, 0);
      waitIdle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
